// File: rtl/led_matrix_scan_ctrl.sv
// 5-column LED matrix scanner: blank-then-drive column slots, alternating the row source every DWELL_FRAMES frames.
// Column/source changes land on the BLANK entry edge; frame_done is combinational in the last slot cycle; no backpressure.
module led_matrix_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int DWELL_FRAMES = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       hold_req,
    input  logic       hold_src,
    output logic [4:0] cols_n,
    output logic [2:0] col_idx,
    output logic       bin_number_sel,
    output logic       rows_oe,
    output logic       frame_done,
    output logic       src_switched
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [19:0] SLOT_LAST  = 20'(CLK_DIV - 1);
    localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL_FRAMES - 1);
    localparam logic [2:0]  COL_LAST   = 3'd4;

    state_t      state_q, state_d;
    logic [19:0] slot_q,  slot_d;
    logic [2:0]  col_q,   col_d;
    logic [7:0]  frm_q,   frm_d;
    logic        src_q,   src_d;
    logic        sw_q,    sw_d;

    logic        slot_end;
    logic        frame_end;

    assign slot_end  = (state_q == ST_DRIVE) && (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (col_q == COL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            slot_q  <= 20'd0;
            col_q   <= 3'd0;
            frm_q   <= 8'd0;
            src_q   <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            col_q   <= col_d;
            frm_q   <= frm_d;
            src_q   <= src_d;
            sw_q    <= sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        col_d   = col_q;
        frm_d   = frm_q;
        src_d   = src_q;
        sw_d    = 1'b0;

        if (!enable) begin
            // Source is deliberately kept so a re-enable resumes on the same data.
            state_d = ST_IDLE;
            slot_d  = 20'd0;
            col_d   = 3'd0;
            frm_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    slot_d  = 20'd0;
                    col_d   = 3'd0;
                end
                ST_BLANK: begin
                    slot_d = slot_q + 20'd1;
                    if (slot_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (slot_end) begin
                        state_d = ST_BLANK;
                        slot_d  = 20'd0;
                        col_d   = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
                        if (hold_req) begin
                            src_d = hold_src;
                            sw_d  = (hold_src != src_q);
                        end else if (frame_end) begin
                            if (frm_q == DWELL_LAST) begin
                                frm_d = 8'd0;
                                src_d = ~src_q;
                                sw_d  = 1'b1;
                            end else begin
                                frm_d = frm_q + 8'd1;
                            end
                        end
                    end else begin
                        slot_d = slot_q + 20'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = 20'd0;
                    col_d   = 3'd0;
                end
            endcase

            // Dwell restarts from zero once hold_req drops.
            if (hold_req) begin
                frm_d = 8'd0;
            end
        end
    end

    assign rows_oe        = (state_q == ST_DRIVE);
    assign cols_n         = rows_oe ? ~(5'b00001 << col_q) : 5'b11111;
    assign col_idx        = col_q;
    assign bin_number_sel = src_q;
    assign frame_done     = enable && frame_end;
    assign src_switched   = sw_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Randomised and directed bench for led_matrix_scan_ctrl against a cycle-position reference model.
module tb_led_matrix_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int DWELL     = 3;
    localparam int FRAME     = 5 * CLK_DIV;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       enable   = 1'b0;
    logic       hold_req = 1'b0;
    logic       hold_src = 1'b0;
    logic [4:0] cols_n;
    logic [2:0] col_idx;
    logic       bin_number_sel;
    logic       rows_oe;
    logic       frame_done;
    logic       src_switched;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_matrix_scan_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .DWELL_FRAMES(DWELL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .hold_req      (hold_req),
        .hold_src      (hold_src),
        .cols_n        (cols_n),
        .col_idx       (col_idx),
        .bin_number_sel(bin_number_sel),
        .rows_oe       (rows_oe),
        .frame_done    (frame_done),
        .src_switched  (src_switched)
    );

    // Reference: position within the frame since scanning started, plus source/dwell bookkeeping.
    bit m_run    = 0;
    int m_t      = 0;
    bit m_src    = 0;
    int m_frames = 0;
    bit m_sw     = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_t = 0; m_src = 0; m_frames = 0; m_sw = 0;
        end else begin
            m_sw = 0;
            if (!enable) begin
                m_run = 0; m_t = 0; m_frames = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
                if (hold_req) m_frames = 0;
            end else begin
                if (m_t % CLK_DIV == CLK_DIV - 1) begin
                    if (hold_req) begin
                        if (m_src != hold_src) begin
                            m_src = hold_src; m_sw = 1;
                        end
                    end else if (m_t / CLK_DIV == 4) begin
                        m_frames++;
                        if (m_frames == DWELL) begin
                            m_frames = 0; m_src = !m_src; m_sw = 1;
                        end
                    end
                end
                if (hold_req) m_frames = 0;
                m_t = (m_t + 1) % FRAME;
            end
        end
    end

    function automatic logic [11:0] exp_vec();
        int   pos;
        int   col;
        logic drive;
        logic [4:0] one_hot;
        pos     = m_t % CLK_DIV;
        col     = m_t / CLK_DIV;
        drive   = m_run && (pos >= BLANK_CYC);
        one_hot = 5'b00001 << col;
        exp_vec = {drive ? ~one_hot : 5'b11111,
                   m_run ? 3'(col) : 3'd0,
                   m_src, drive,
                   m_run && enable && (pos == CLK_DIV - 1) && (col == 4),
                   m_sw};
    endfunction

    wire [11:0] dut_vec = {cols_n, col_idx, bin_number_sel, rows_oe, frame_done, src_switched};

    logic prev_sel = 1'b0;

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (dut_vec !== 12'b11111_000_0000)
            $display("FAIL reset_outputs: got %b expected %b", dut_vec, 12'b11111_000_0000);
        @(negedge clk);
        checks++;
        if (dut_vec !== 12'b11111_000_0000)
            $display("FAIL reset_hold: got %b expected %b", dut_vec, 12'b11111_000_0000);
        errors += (dut_vec !== 12'b11111_000_0000) ? 1 : 0;
    endtask

    task automatic test_scan();
        logic [11:0] e;
        enable = 1'b1;
        @(negedge clk);
        reset_n  = 1'b1;
        prev_sel = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL scan_cycle%0d: got %b expected %b", i, dut_vec, e);
            end
            checks++;
            if (frame_done !== (i % FRAME == 0)) begin
                errors++;
                $display("FAIL scan_frame_done_period cycle%0d: got %b expected %b", i, frame_done, (i % FRAME == 0));
            end
            if (i == 121) begin
                checks++;
                if ({bin_number_sel, src_switched, cols_n} !== {1'b1, 1'b1, 5'b11111}) begin
                    errors++;
                    $display("FAIL scan_src_toggle: got %b expected %b", {bin_number_sel, src_switched, cols_n}, 7'b1111111);
                end
            end
            checks++;
            if (rows_oe !== ($countones(~cols_n) == 1)) begin
                errors++;
                $display("FAIL scan_oe_vs_cols: rows_oe %b cols_n %b", rows_oe, cols_n);
            end
            checks++;
            if (rows_oe && (bin_number_sel !== prev_sel)) begin
                errors++;
                $display("FAIL scan_sel_in_drive: sel %b prev %b", bin_number_sel, prev_sel);
            end
            prev_sel = bin_number_sel;
        end
    endtask

    task automatic test_hold();
        logic [11:0] e;
        int sw_count;
        checks++;
        if (bin_number_sel !== 1'b1) begin
            errors++;
            $display("FAIL hold_pre_src: got %b expected 1", bin_number_sel);
        end
        hold_src = 1'b0;
        hold_req = 1'b1;
        sw_count = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            @(negedge clk);
            e = exp_vec();
            sw_count += src_switched ? 1 : 0;
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %b expected %b", i, dut_vec, e);
            end
        end
        checks++;
        if (bin_number_sel !== 1'b0 || sw_count != 1) begin
            errors++;
            $display("FAIL hold_forced_src: got sel %b switches %0d expected sel 0 switches 1", bin_number_sel, sw_count);
        end
        hold_req = 1'b0;
        for (int i = 0; i < 3 * FRAME + 5; i++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL hold_release_cycle%0d: got %b expected %b", i, dut_vec, e);
            end
        end
        checks++;
        if (bin_number_sel !== 1'b1) begin
            errors++;
            $display("FAIL hold_resume_toggle: got %b expected 1", bin_number_sel);
        end
    endtask

    task automatic test_enable_drop();
        logic [11:0] e;
        bit   found;
        logic saved;
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (m_run && (m_t / CLK_DIV == 2) && (m_t % CLK_DIV == BLANK_CYC + 2)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL enable_drop_timeout: got no column-2 drive expected one within %0d cycles", 4 * FRAME);
        end
        saved  = m_src;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== {5'b11111, 3'd0, saved, 3'b000}) begin
            errors++;
            $display("FAIL enable_drop_idle: got %b expected %b", dut_vec, {5'b11111, 3'd0, saved, 3'b000});
        end
        repeat (3) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL reenable_cycle%0d: got %b expected %b", i, dut_vec, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (m_run && (m_t % CLK_DIV >= BLANK_CYC) && (m_t % CLK_DIV < CLK_DIV - 1)) found = 1;
        end
        checks++;
        if (!found || rows_oe !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup: got found %0d rows_oe %b expected 1 1", found, rows_oe);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 12'b11111_000_0000) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b expected %b", dut_vec, 12'b11111_000_0000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL post_reset_cycle%0d: got %b expected %b", i, dut_vec, e);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        prev_sel = bin_number_sel;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, dut_vec, e);
            end
            checks++;
            if (rows_oe !== ($countones(~cols_n) == 1)) begin
                errors++;
                $display("FAIL random_oe_vs_cols: rows_oe %b cols_n %b", rows_oe, cols_n);
            end
            checks++;
            if (rows_oe && (bin_number_sel !== prev_sel)) begin
                errors++;
                $display("FAIL random_sel_in_drive: sel %b prev %b", bin_number_sel, prev_sel);
            end
            prev_sel = bin_number_sel;
            if ($urandom_range(63, 0) == 0) enable   = ~enable;
            if ($urandom_range(49, 0) == 0) hold_req = ~hold_req;
            if ($urandom_range(7, 0) == 0)  hold_src = $urandom_range(1, 0) == 1;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hold();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
